// File: rtl/frame_tick_receiver_if.sv
// Frame-tick bus: slow clock, step button and mode in; tick, frame count,
// stall flag and debounced button level out.
interface frame_tick_if #(
    parameter int W = 32
);
    logic         slow_clk;
    logic         step_button;
    logic         manual_mode;
    logic         tick;
    logic [W-1:0] frame_count;
    logic         stall;
    logic         btn_state;

    modport master (
        output slow_clk, step_button, manual_mode,
        input  tick, frame_count, stall, btn_state
    );

    modport slave (
        input  slow_clk, step_button, manual_mode,
        output tick, frame_count, stall, btn_state
    );
endinterface

// File: rtl/frame_tick_receiver.sv
// Turns the divided slow clock (auto) or a debounced step button (manual) into
// single-cycle clk_in ticks. Define FRAME_COUNT_SAT_EN to saturate frame_count.
module frame_tick_receiver #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int W               = 32,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic        clk_in,
    input  logic        reset,
    frame_tick_if.slave ftr
);
    localparam int DB_CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WD_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_CNT_W-1:0] DB_ZERO = {DB_CNT_W{1'b0}};
    localparam logic [DB_CNT_W-1:0] DB_ONE  = DB_CNT_W'(32'd1);
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
    localparam logic [WD_W-1:0]     WD_ZERO = {WD_W{1'b0}};
    localparam logic [WD_W-1:0]     WD_ONE  = WD_W'(32'd1);
    localparam logic [WD_W-1:0]     WD_LAST = WD_W'(TIMEOUT_CYCLES - 32'sd1);
    localparam logic [W-1:0]        FC_ZERO = {W{1'b0}};
    localparam logic [W-1:0]        FC_ONE  = W'(32'd1);
    localparam logic [W-1:0]        FC_MAX  = {W{1'b1}};

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_t;

    logic [SYNC_STAGES-1:0] slow_sync_r;
    logic [SYNC_STAGES-1:0] btn_sync_r;
    logic                   slow_prev_r;
    logic                   mode_r;
    db_state_t              state_r;
    logic [DB_CNT_W-1:0]    cnt_r;
    logic                   lock_r;
    logic                   btn_state_r;
    logic                   tick_r;
    logic [W-1:0]           frame_count_r;
    logic [WD_W-1:0]        wd_r;
    logic                   stall_r;

    logic                   slow_last_s;
    logic                   btn_last_s;
    logic                   switch_s;
    logic                   auto_edge_s;
    logic                   press_accept_s;
    logic                   tick_nxt_s;
    logic [WD_W-1:0]        wd_inc_s;

    assign slow_last_s = slow_sync_r[SYNC_STAGES-1];
    assign btn_last_s  = btn_sync_r[SYNC_STAGES-1];

    assign ftr.tick        = tick_r;
    assign ftr.frame_count = frame_count_r;
    assign ftr.stall       = stall_r;
    assign ftr.btn_state   = btn_state_r;

    // Synchronizer chains and the slow-clock edge-detect register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            slow_sync_r <= {SYNC_STAGES{1'b0}};
            btn_sync_r  <= {SYNC_STAGES{1'b0}};
            slow_prev_r <= 1'b0;
        end else begin
            slow_sync_r <= {slow_sync_r[SYNC_STAGES-2:0], ftr.slow_clk};
            btn_sync_r  <= {btn_sync_r[SYNC_STAGES-2:0], ftr.step_button};
            slow_prev_r <= slow_last_s;
        end
    end

    // Registered copy of the mode; loaded during reset so leaving reset is not a switch.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            mode_r <= ftr.manual_mode;
        end else begin
            mode_r <= ftr.manual_mode;
        end
    end

    // Next-tick decision shared by the debounce FSM and the watchdog.
    always_comb begin
        switch_s       = (mode_r != ftr.manual_mode);
        auto_edge_s    = slow_last_s & ~slow_prev_r;
        press_accept_s = (state_r == ST_PRESS_WAIT) && btn_last_s && (cnt_r >= DB_LAST);
        if (switch_s) begin
            tick_nxt_s = 1'b0;
        end else if (ftr.manual_mode) begin
            tick_nxt_s = press_accept_s;
        end else begin
            tick_nxt_s = auto_edge_s;
        end
        if (wd_r == WD_LAST) begin
            wd_inc_s = wd_r;
        end else begin
            wd_inc_s = wd_r + WD_ONE;
        end
    end

    // Debounce FSM plus the tick register. After a mode switch the lock keeps a
    // button held across the switch from being accepted until it is seen released.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r     <= ST_RELEASED;
            cnt_r       <= DB_ZERO;
            lock_r      <= 1'b0;
            btn_state_r <= 1'b0;
            tick_r      <= 1'b0;
        end else begin
            tick_r <= tick_nxt_s;
            if (switch_s) begin
                state_r     <= ST_RELEASED;
                cnt_r       <= DB_ZERO;
                lock_r      <= 1'b1;
                btn_state_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_RELEASED: begin
                        if (!btn_last_s) begin
                            lock_r <= 1'b0;
                        end else if (!lock_r) begin
                            state_r <= ST_PRESS_WAIT;
                            cnt_r   <= DB_ONE;
                        end else begin
                            state_r <= ST_RELEASED;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!btn_last_s) begin
                            state_r <= ST_RELEASED;
                            cnt_r   <= DB_ZERO;
                        end else if (cnt_r >= DB_LAST) begin
                            state_r     <= ST_PRESSED;
                            cnt_r       <= DB_ZERO;
                            btn_state_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + DB_ONE;
                        end
                    end
                    ST_PRESSED: begin
                        if (!btn_last_s) begin
                            state_r <= ST_RELEASE_WAIT;
                            cnt_r   <= DB_ONE;
                        end else begin
                            state_r <= ST_PRESSED;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (btn_last_s) begin
                            state_r <= ST_PRESSED;
                            cnt_r   <= DB_ZERO;
                        end else if (cnt_r >= DB_LAST) begin
                            state_r     <= ST_RELEASED;
                            cnt_r       <= DB_ZERO;
                            btn_state_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + DB_ONE;
                        end
                    end
                    default: begin
                        state_r     <= ST_RELEASED;
                        cnt_r       <= DB_ZERO;
                        btn_state_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Frame counter, advanced the cycle after each tick.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            frame_count_r <= FC_ZERO;
        end else if (tick_r) begin
`ifdef FRAME_COUNT_SAT_EN
            if (frame_count_r != FC_MAX) begin
                frame_count_r <= frame_count_r + FC_ONE;
            end else begin
                frame_count_r <= frame_count_r;
            end
`else
            frame_count_r <= frame_count_r + FC_ONE;
`endif
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    // Auto-mode watchdog; stall rises as the counter lands on its last value.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wd_r    <= WD_ZERO;
            stall_r <= 1'b0;
        end else if (switch_s || ftr.manual_mode || tick_nxt_s) begin
            wd_r    <= WD_ZERO;
            stall_r <= 1'b0;
        end else begin
            wd_r    <= wd_inc_s;
            stall_r <= (wd_inc_s == WD_LAST);
        end
    end
endmodule

// File: tb/tb_frame_tick_receiver.sv
// Directed bench for frame_tick_receiver with a cycle-level behavioural model.
module tb_frame_tick_receiver;
    localparam int S   = 2;
    localparam int DEB = 4;
    localparam int W   = 3;
    localparam int TO  = 50;
    localparam int FC_MAX = (1 << W) - 1;
    localparam int NEED = (DEB < 2) ? 2 : DEB;

    logic clk_in = 1'b0;
    logic reset;
    frame_tick_if #(.W(W)) bus ();

    frame_tick_receiver #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB), .W(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .ftr   (bus)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int tick_cnt = 0;
    bit started = 1'b0;

    // Model state: input history, debounced level, frame count, watchdog age.
    logic [S+1:0] sh, bh;
    bit exp_tick, exp_stall, exp_btn, lvl, lock, prev_md;
    int exp_fc, age, run;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit md, sw, press, edge_s;
        md = bus.manual_mode;
        if (reset) begin
            sh = '0; bh = '0;
            exp_tick = 0; exp_stall = 0; exp_btn = 0; exp_fc = 0;
            age = 0; lvl = 0; lock = 0; run = 0; prev_md = md;
        end else begin
            sh = {sh[S:0], bus.slow_clk};
            bh = {bh[S:0], bus.step_button};
            sw = (md != prev_md);
            prev_md = md;
            if (exp_tick) begin
`ifdef FRAME_COUNT_SAT_EN
                if (exp_fc < FC_MAX) exp_fc = exp_fc + 1;
`else
                exp_fc = (exp_fc + 1) % (FC_MAX + 1);
`endif
            end
            press = 0;
            if (sw) begin
                lvl = 0; run = 0; lock = 1;
            end else if (bh[S] == lvl) begin
                run = 0;
                if (!lvl) lock = 0;
            end else if (!lvl && lock) begin
                run = 0;
            end else begin
                run++;
                if (run >= NEED) begin
                    lvl = !lvl; run = 0; press = lvl;
                end
            end
            exp_btn = lvl;
            edge_s = sh[S] && !sh[S+1];
            exp_tick = !sw && (md ? press : edge_s);
            if (sw || md || exp_tick) begin
                age = 0; exp_stall = 0;
            end else begin
                if (age < TO - 1) age++;
                exp_stall = (age >= TO - 1);
            end
        end
        started = 1'b1;
    endtask

    always @(posedge clk_in) model_step();

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (started) begin
            chk("tick", int'(bus.tick), int'(exp_tick));
            chk("frame_count", int'(bus.frame_count), exp_fc);
            chk("stall", int'(bus.stall), int'(exp_stall));
            chk("btn_state", int'(bus.btn_state), int'(exp_btn));
            if (bus.tick === 1'b1) tick_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    initial begin
        int t0;
        bit seen;
        bit pat_press[9] = '{1, 0, 1, 0, 1, 1, 1, 1, 1};
        bit pat_rel[7]   = '{0, 1, 0, 0, 0, 0, 0};

        reset = 1'b1;
        bus.slow_clk = 1'b0; bus.step_button = 1'b0; bus.manual_mode = 1'b0;
        step(3);
        chk("reset_tick", int'(bus.tick), 0);
        chk("reset_fc", int'(bus.frame_count), 0);
        chk("reset_stall", int'(bus.stall), 0);
        chk("reset_btn", int'(bus.btn_state), 0);
        reset = 1'b0;
        step(2);

        // Auto ticks: slow_clk period 10, latency pinned on the first rise.
        t0 = tick_cnt;
        bus.slow_clk = 1'b1;
        step(1); chk("lat_edge1", int'(bus.tick), 0);
        step(1); chk("lat_edge2", int'(bus.tick), 0);
        step(1); chk("lat_edge3_tick", int'(bus.tick), 1);
        step(1); chk("tick_width", int'(bus.tick), 0);
        step(1); bus.slow_clk = 1'b0;
        step(5); bus.slow_clk = 1'b1;
        step(5); bus.slow_clk = 1'b0;
        step(5);
        chk("auto_ticks", tick_cnt - t0, 2);
        chk("auto_fc", int'(bus.frame_count), 2);
        chk("auto_stall", int'(bus.stall), 0);

        // Watchdog with slow_clk stuck low, then recovery on the next rise.
        step(50);
        chk("wd_stall_set", int'(bus.stall), 1);
        bus.slow_clk = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bus.tick === 1'b1) begin
                seen = 1'b1;
                chk("wd_stall_clear_on_tick", int'(bus.stall), 0);
                break;
            end
        end
        chk("wd_tick_seen", int'(seen), 1);
        step(3);
        chk("wd_fc", int'(bus.frame_count), 3);

        // Bounce rejection in manual mode.
        bus.manual_mode = 1'b1;
        step(3);
        t0 = tick_cnt;
        foreach (pat_press[i]) begin
            bus.step_button = pat_press[i];
            step(1);
        end
        step(4);
        chk("bounce_press_ticks", tick_cnt - t0, 1);
        chk("bounce_btn_high", int'(bus.btn_state), 1);
        foreach (pat_rel[i]) begin
            bus.step_button = pat_rel[i];
            step(1);
        end
        step(4);
        chk("bounce_release_ticks", tick_cnt - t0, 1);
        chk("bounce_btn_low", int'(bus.btn_state), 0);

        // Reset in the middle of PRESS_WAIT, then a long hold gives one tick.
        bus.step_button = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        chk("midpw_reset_tick", int'(bus.tick), 0);
        chk("midpw_reset_fc", int'(bus.frame_count), 0);
        chk("midpw_reset_stall", int'(bus.stall), 0);
        chk("midpw_reset_btn", int'(bus.btn_state), 0);
        reset = 1'b0;
        bus.step_button = 1'b0;
        step(3);
        t0 = tick_cnt;
        bus.step_button = 1'b1;
        step(100);
        chk("held_ticks", tick_cnt - t0, 1);
        chk("held_fc", int'(bus.frame_count), 1);
        bus.step_button = 1'b0;
        step(8);

        // Mode switches: no spurious auto edge, held button needs a re-press.
        bus.slow_clk = 1'b1;
        step(5);
        t0 = tick_cnt;
        bus.manual_mode = 1'b0;
        step(10);
        chk("switch_to_auto_no_tick", tick_cnt - t0, 0);
        bus.step_button = 1'b1;
        step(10);
        bus.manual_mode = 1'b1;
        step(20);
        chk("held_across_switch_no_tick", tick_cnt - t0, 0);
        chk("held_across_switch_btn", int'(bus.btn_state), 0);
        bus.step_button = 1'b0;
        step(8);
        bus.step_button = 1'b1;
        step(10);
        chk("repress_tick", tick_cnt - t0, 1);

        // Nine ticks on a 3-bit counter: wrap or saturate.
        bus.manual_mode = 1'b0;
        bus.step_button = 1'b0;
        bus.slow_clk = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);
        t0 = tick_cnt;
        repeat (9) begin
            bus.slow_clk = 1'b1; step(5);
            bus.slow_clk = 1'b0; step(5);
        end
        step(4);
        chk("wrap_ticks", tick_cnt - t0, 9);
`ifdef FRAME_COUNT_SAT_EN
        chk("wrap_fc", int'(bus.frame_count), 7);
`else
        chk("wrap_fc", int'(bus.frame_count), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/frame_tick_receiver.md
Name: frame_tick_receiver

Overview:
- Consumer end of the frame-clock path: accepts the divided slow clock (auto mode) or the manual step button (manual mode) and converts it into clean single-cycle `tick` enables in the `clk_in` domain.
- Game logic uses `tick` as its frame-advance enable instead of clocking from the slow clock directly.
- Also maintains a frame counter and a watchdog that flags a stalled slow clock.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on `slow_clk` and `step_button` (legal 2..4)
- DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a button press or release (>=1)
- W, 32, width of `frame_count`
- TIMEOUT_CYCLES, 1000000, `clk_in` cycles without a tick in auto mode before `stall` asserts

Ports:
- clk_in  input  1  system clock
- reset  input  1  synchronous, active-high
- slow_clk  input  1  divided frame clock; asynchronous to `clk_in`
- step_button  input  1  raw manual step button, bouncy
- manual_mode  input  1  1 = ticks from button, 0 = ticks from `slow_clk`; quasi-static, already in `clk_in` domain
- tick  output  1  one-cycle frame-advance pulse
- frame_count  output  W  number of ticks since reset
- stall  output  1  auto-mode watchdog flag
- btn_state  output  1  debounced button level

Behaviour:
- Reset: all of the following are 0:
  - `tick`, `frame_count`, `stall`, `btn_state`
  - synchronizer chains, edge-detect register, watchdog counter, debounce counter
  - FSM state is RELEASED.
  - Reset takes priority over all other events, including mid-debounce and mid-count.
- Synchronizers: `slow_clk` and `step_button` each pass through SYNC_STAGES flops. Only the last stage is used.
- Auto path (`manual_mode` = 0):
  - Rising edge of the synchronized `slow_clk` (last stage 1, previous-sample register 0) gives `tick` = 1 for exactly one cycle.
  - Latency: `tick` is high on the (SYNC_STAGES+1)th `clk_in` edge after the first edge that samples `slow_clk` high.
  - Falling edges produce nothing.
- Manual path: debounce FSM on the synchronized button, always running. `btn_state` = 1 in PRESSED and RELEASE_WAIT.
  - RELEASED: sample 1 -> PRESS_WAIT, cnt = 1.
  - PRESS_WAIT:
    - sample 0 -> RELEASED, cnt = 0.
    - sample 1 and cnt == DEBOUNCE_CYCLES-1 -> PRESSED; emit `tick` if `manual_mode` = 1.
    - otherwise cnt++.
  - PRESSED: sample 0 -> RELEASE_WAIT, cnt = 1.
  - RELEASE_WAIT:
    - sample 1 -> PRESSED, no tick.
    - sample 0 and cnt == DEBOUNCE_CYCLES-1 -> RELEASED.
    - otherwise cnt++.
  - DEBOUNCE_CYCLES = 1: PRESS_WAIT and RELEASE_WAIT last one cycle.
  - Result: exactly one tick per accepted press. Holding the button never re-ticks.
- Mode switch: any change of `manual_mode` (registered copy compared with current value) causes:
  - `tick` suppressed in that cycle;
  - edge-detect register reloaded with the current synchronized `slow_clk` level, so no spurious edge;
  - watchdog cleared, `stall` cleared;
  - debounce FSM forced to RELEASED with cnt = 0. A button held across the switch must be released and re-pressed.
- frame_count: increments by 1 in the cycle after `tick`. Wraps from 2^W-1 to 0 (see Optional Feature).
- Watchdog:
  - Auto mode only. Counter clears on `tick` and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1: `stall` = 1 and the counter holds.
  - `stall` clears in the cycle `tick` asserts.
  - In manual mode the counter is held at 0 and `stall` = 0.
- Simultaneous events, in priority order: reset > mode switch > tick generation > watchdog.

Optional Feature:
- Macro FRAME_COUNT_SAT_EN.
- Defined: `frame_count` saturates at 2^W-1; further ticks still pulse but the count holds.
- Undefined: `frame_count` wraps modulo 2^W.

Test Plan:
- Auto tick: SYNC_STAGES=2, `slow_clk` period 10 clk_in, 20 cycles -> 2 ticks, each 1 cycle wide, 3 cycles after the rising edge is first sampled; `frame_count` = 2; `stall` = 0.
- Bounce rejection: DEBOUNCE_CYCLES=4, manual, button toggles 1,0,1,0,1 on consecutive cycles, then held high for 4 cycles -> exactly 1 tick; `btn_state` = 1; release bounce 0,1,0 then low for 4 cycles -> no tick, `btn_state` = 0.
- Held button: manual, button held high 100 cycles -> 1 tick only; `frame_count` = 1.
- Watchdog: TIMEOUT_CYCLES=50, auto, `slow_clk` stuck low -> `stall` = 1 at cycle 49 after last tick; next `slow_clk` rise -> `stall` = 0 on the tick cycle.
- Mode switch: `slow_clk` held high, switch manual -> auto -> no tick; button held high across auto -> manual -> no tick until released and re-pressed.
- Wrap/saturate and reset: W=3, 9 ticks -> `frame_count` = 1 without macro, 7 with FRAME_COUNT_SAT_EN; assert reset mid-PRESS_WAIT -> all outputs 0 next cycle, FSM RELEASED.
